// File: rtl/usb4_ser_pkg.sv
// Shared lengths, gen_speed encodings and FSM state type for the
// two-lane encoded-symbol serializer.
package usb4_ser_pkg;

  localparam int SYM_W     = 132;
  localparam int NUM_LANES = 2;
  localparam int CNT_W     = 8;

  localparam logic [CNT_W-1:0] SYM_LEN_GEN2 = 8'd66;
  localparam logic [CNT_W-1:0] SYM_LEN_GEN3 = 8'd132;
  localparam logic [CNT_W-1:0] SYM_LEN_GEN4 = 8'd8;

  localparam logic [1:0] GEN_SPEED_GEN4 = 2'd0;
  localparam logic [1:0] GEN_SPEED_GEN3 = 2'd1;
  localparam logic [1:0] GEN_SPEED_GEN2 = 2'd2;
  localparam logic [1:0] GEN_SPEED_RSVD = 2'd3;

  typedef enum logic {IDLE, SHIFT} ser_state_e;

  // Reserved speed yields length 0; callers never load such a symbol.
  function automatic logic [CNT_W-1:0] len_of(input logic [1:0] gen_speed);
    case (gen_speed)
      GEN_SPEED_GEN2: len_of = SYM_LEN_GEN2;
      GEN_SPEED_GEN3: len_of = SYM_LEN_GEN3;
      GEN_SPEED_GEN4: len_of = SYM_LEN_GEN4;
      default:        len_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/ser_lane_shifter.sv
// One lane's hold register and LSB-first shift register; sequencing is
// driven entirely by the shared controller in lanes_serializer.
module ser_lane_shifter
  import usb4_ser_pkg::*;
(
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             load_i,
  input  logic             hold_load_i,
  input  logic             xfer_i,
  input  logic             shift_i,
  input  logic [SYM_W-1:0] data_i,
  output logic             bit_o
);

  logic [SYM_W-1:0] shreg_q;
  logic [SYM_W-1:0] hold_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      shreg_q <= '0;
      hold_q  <= '0;
    end else begin
      if (load_i)
        shreg_q <= data_i;
      else if (xfer_i)
        shreg_q <= hold_q;
      else if (shift_i)
        shreg_q <= {1'b0, shreg_q[SYM_W-1:1]};
      if (hold_load_i)
        hold_q <= data_i;
    end
  end

  assign bit_o = shreg_q[0];

endmodule

// File: rtl/lanes_serializer.sv
// Two-lane symbol serializer with one-deep hold buffer and underflow flag.
// Optional SER_UNDERFLOW_CNT_EN adds a saturating underflow counter.
module lanes_serializer
  import usb4_ser_pkg::*;
(
  input  logic             ser_clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       gen_speed,
  input  logic [SYM_W-1:0] lane_0_tx_enc_old,
  input  logic [SYM_W-1:0] lane_1_tx_enc_old,
  input  logic             enable_ser,
  output logic             sym_ready,
  output logic             lane_0_tx_out,
  output logic             lane_1_tx_out,
  output logic             tx_valid,
  output logic             sym_start,
  output logic             underflow,
  output logic [15:0]      underflow_cnt
);

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] hold_len_q, hold_len_d;
  logic             hold_full_q, hold_full_d;
  logic             sym_ready_q;
  logic             underflow_q, underflow_d;

  logic             clear, acc, last_bit;
  logic [CNT_W-1:0] acc_len;
  logic             ld_direct, ld_hold, xfer, shift;

  assign clear     = rst || !enable;
  assign sym_ready = sym_ready_q && enable && !rst;
  // A reserved-speed symbol completes the handshake but is discarded.
  assign acc       = enable_ser && sym_ready && (gen_speed != GEN_SPEED_RSVD);
  assign acc_len   = len_of(gen_speed);
  assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == len_q - 8'd1);

  assign ld_direct = acc && ((state_q == IDLE) || (last_bit && !hold_full_q));
  assign ld_hold   = acc && (state_q == SHIFT) && !last_bit;
  assign xfer      = last_bit && hold_full_q;
  assign shift     = (state_q == SHIFT) && !last_bit;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    len_d       = len_q;
    hold_len_d  = hold_len_q;
    hold_full_d = hold_full_q;
    underflow_d = 1'b0;
    if (state_q == IDLE) begin
      if (acc) begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
        len_d     = acc_len;
      end
    end else if (!last_bit) begin
      bit_cnt_d = bit_cnt_q + 8'd1;
      if (acc) begin
        hold_full_d = 1'b1;
        hold_len_d  = acc_len;
      end
    end else if (hold_full_q) begin
      bit_cnt_d   = '0;
      len_d       = hold_len_q;
      hold_full_d = 1'b0;
    end else if (acc) begin
      bit_cnt_d = '0;
      len_d     = acc_len;
    end else begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge ser_clk) begin
    if (clear) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      len_q       <= '0;
      hold_len_q  <= '0;
      hold_full_q <= 1'b0;
      sym_ready_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      len_q       <= len_d;
      hold_len_q  <= hold_len_d;
      hold_full_q <= hold_full_d;
      sym_ready_q <= !hold_full_d;
      underflow_q <= underflow_d;
    end
  end

  logic [SYM_W-1:0]     enc_data [NUM_LANES];
  logic [NUM_LANES-1:0] tx_bit;

  assign enc_data[0] = lane_0_tx_enc_old;
  assign enc_data[1] = lane_1_tx_enc_old;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      ser_lane_shifter u_shifter (
        .clk_i       (ser_clk),
        .srst_i      (clear),
        .load_i      (ld_direct),
        .hold_load_i (ld_hold),
        .xfer_i      (xfer),
        .shift_i     (shift),
        .data_i      (enc_data[gi]),
        .bit_o       (tx_bit[gi])
      );
    end
  endgenerate

  assign tx_valid      = (state_q == SHIFT);
  assign sym_start     = tx_valid && (bit_cnt_q == '0);
  assign lane_0_tx_out = tx_valid && tx_bit[0];
  assign lane_1_tx_out = tx_valid && tx_bit[1];
  assign underflow     = underflow_q;

`ifdef SER_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_q;

  always_ff @(posedge ser_clk) begin
    if (clear)
      uf_cnt_q <= '0;
    else if (underflow_d && (uf_cnt_q != 16'hFFFF))
      uf_cnt_q <= uf_cnt_q + 16'd1;
  end

  assign underflow_cnt = uf_cnt_q;
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_lanes_serializer.sv
// Randomized self-checking bench for lanes_serializer against a queue-based
// symbol-stream model; honours SER_UNDERFLOW_CNT_EN like the design.
module tb_lanes_serializer;

  logic         ser_clk;
  logic         rst;
  logic         enable;
  logic [1:0]   gen_speed;
  logic [131:0] lane_0_tx_enc_old;
  logic [131:0] lane_1_tx_enc_old;
  logic         enable_ser;
  logic         sym_ready;
  logic         lane_0_tx_out;
  logic         lane_1_tx_out;
  logic         tx_valid;
  logic         sym_start;
  logic         underflow;
  logic [15:0]  underflow_cnt;

  lanes_serializer dut (
    .ser_clk           (ser_clk),
    .rst               (rst),
    .enable            (enable),
    .gen_speed         (gen_speed),
    .lane_0_tx_enc_old (lane_0_tx_enc_old),
    .lane_1_tx_enc_old (lane_1_tx_enc_old),
    .enable_ser        (enable_ser),
    .sym_ready         (sym_ready),
    .lane_0_tx_out     (lane_0_tx_out),
    .lane_1_tx_out     (lane_1_tx_out),
    .tx_valid          (tx_valid),
    .sym_start         (sym_start),
    .underflow         (underflow),
    .underflow_cnt     (underflow_cnt)
  );

  initial ser_clk = 1'b0;
  always #5 ser_clk = ~ser_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queue of whole symbols in flight (head is being transmitted,
  // a second entry means the hold buffer is occupied).
  typedef struct {
    logic [131:0] d0;
    logic [131:0] d1;
    int           len;
  } sym_t;

  sym_t sq[$];
  int   pos       = 0;
  bit   prev_ok   = 0;
  bit   m_uf      = 0;
  int   m_cnt     = 0;
  int   acc_total = 0;

  function automatic int len_model(input logic [1:0] g);
    case (g)
      2'd2:    return 66;
      2'd1:    return 132;
      2'd0:    return 8;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_ready();
    return prev_ok && enable && !rst && (sq.size() < 2);
  endfunction

  function automatic logic [131:0] rand132();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[131:0];
  endfunction

  function automatic logic [5:0] dut_vec();
    return {lane_0_tx_out, lane_1_tx_out, tx_valid, sym_start, underflow, sym_ready};
  endfunction

  function automatic logic [5:0] exp_vec();
    logic b0, b1, v, st;
    b0 = 1'b0; b1 = 1'b0; v = 1'b0; st = 1'b0;
    if (sq.size() > 0) begin
      v  = 1'b1;
      b0 = sq[0].d0[pos];
      b1 = sq[0].d1[pos];
      st = (pos == 0);
    end
    return {b0, b1, v, st, m_uf, m_ready()};
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef SER_UNDERFLOW_CNT_EN
    return m_cnt[15:0];
`else
    return 16'd0;
`endif
  endfunction

  task automatic tick();
    bit   acc, clr;
    sym_t s;
    acc    = enable_ser && m_ready() && (gen_speed != 2'd3);
    clr    = rst || !enable;
    s.d0   = lane_0_tx_enc_old;
    s.d1   = lane_1_tx_enc_old;
    s.len  = len_model(gen_speed);
    @(posedge ser_clk);
    if (clr) begin
      sq.delete();
      pos = 0; m_uf = 0; m_cnt = 0; prev_ok = 0;
    end else begin
      m_uf = 0;
      if (sq.size() > 0) begin
        if (pos == sq[0].len - 1) begin
          void'(sq.pop_front());
          pos = 0;
          if (sq.size() == 0 && !acc) m_uf = 1;
        end else begin
          pos++;
        end
      end
      if (acc) begin
        sq.push_back(s);
        acc_total++;
        $display("[%0t] accept symbol len=%0d lane0[7:0]=%h queued=%0d", $time, s.len, s.d0[7:0], sq.size());
      end
      if (m_uf && m_cnt < 65535) m_cnt++;
      prev_ok = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; enable = 1; enable_ser = 0; gen_speed = 2'd2;
    lane_0_tx_enc_old = '0; lane_1_tx_enc_old = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec() || underflow_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d got=%b cnt=%0d exp=%b cnt=0", k, dut_vec(), underflow_cnt, exp_vec());
      end
    end
  endtask

  task automatic test_gen2_single();
    logic [65:0] g2;
    int n_v, n_start, n_uf;
    g2 = {64'hA5A5_0000_FFFF_1234, 2'b01};
    rst = 0; enable = 1; enable_ser = 0;
    tick();
    gen_speed = 2'd2;
    lane_0_tx_enc_old = {66'd0, g2};
    lane_1_tx_enc_old = {66'd0, ~g2};
    enable_ser = 1;
    tick();
    enable_ser = 0;
    n_v = 0; n_start = 0; n_uf = 0;
    for (int k = 0; k < 70; k++) begin
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL gen2_vec cyc=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
      if (k < 2) begin
        n_checks++;
        if (lane_0_tx_out !== g2[k]) begin
          n_fail++;
          $display("FAIL gen2_first_bits bit=%0d got=%b exp=%b", k, lane_0_tx_out, g2[k]);
        end
      end
      n_v     += int'(tx_valid);
      n_start += int'(sym_start);
      n_uf    += int'(underflow);
      tick();
    end
    n_checks++;
    if (n_v != 66 || n_start != 1 || n_uf != 1) begin
      n_fail++;
      $display("FAIL gen2_counts got valid=%0d start=%0d uf=%0d exp valid=66 start=1 uf=1", n_v, n_start, n_uf);
    end
  endtask

  task automatic test_gen3_back_to_back();
    int start_acc, run, gaps, uf_in_run;
    int starts[$];
    gen_speed = 2'd1; enable_ser = 1;
    start_acc = acc_total; run = 0; gaps = 0; uf_in_run = 0;
    for (int k = 0; k < 410; k++) begin
      lane_0_tx_enc_old = rand132();
      lane_1_tx_enc_old = rand132();
      tick();
      if (acc_total - start_acc >= 3) enable_ser = 0;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL gen3_vec cyc=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
      if (tx_valid) begin
        if (sym_start) starts.push_back(run);
        run++;
      end else if (run > 0 && run < 396) begin
        gaps++;
      end
      if (underflow && run < 396) uf_in_run++;
    end
    n_checks++;
    if (run != 396 || gaps != 0 || uf_in_run != 0) begin
      n_fail++;
      $display("FAIL gen3_stream got valid=%0d gaps=%0d early_uf=%0d exp valid=396 gaps=0 early_uf=0", run, gaps, uf_in_run);
    end
    n_checks++;
    if (starts.size() != 3 || starts[0] != 0 || starts[1] != 132 || starts[2] != 264) begin
      n_fail++;
      $display("FAIL gen3_sym_start got count=%0d exp offsets 0,132,264", starts.size());
    end
  endtask

  task automatic test_gen4();
    logic [131:0] r;
    logic [7:0]   pat;
    pat = 8'h3C;
    r = rand132(); r[7:0] = pat;
    gen_speed = 2'd0;
    lane_0_tx_enc_old = r;
    lane_1_tx_enc_old = rand132();
    enable_ser = 1;
    tick();
    enable_ser = 0;
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL gen4_vec cyc=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
      n_checks++;
      if (k < 8 && (lane_0_tx_out !== pat[k] || tx_valid !== 1'b1)) begin
        n_fail++;
        $display("FAIL gen4_bits bit=%0d got=%b valid=%b exp=%b valid=1", k, lane_0_tx_out, tx_valid, pat[k]);
      end else if (k >= 8 && tx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL gen4_idle cyc=%0d got valid=%b exp valid=0", k, tx_valid);
      end
      tick();
    end
  endtask

  task automatic test_speed_change();
    int start_acc, run;
    int starts[$];
    gen_speed = 2'd2;
    lane_0_tx_enc_old = rand132();
    lane_1_tx_enc_old = rand132();
    enable_ser = 1;
    tick();
    enable_ser = 0;
    start_acc = acc_total; run = 0;
    for (int k = 0; k < 205; k++) begin
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL speed_vec cyc=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
      if (tx_valid) begin
        if (sym_start) starts.push_back(run);
        run++;
      end
      if (k == 30) begin
        gen_speed = 2'd1;
        lane_0_tx_enc_old = rand132();
        lane_1_tx_enc_old = rand132();
        enable_ser = 1;
      end
      tick();
      if (acc_total != start_acc) enable_ser = 0;
    end
    n_checks++;
    if (run != 198 || starts.size() != 2 || starts[0] != 0 || starts[1] != 66) begin
      n_fail++;
      $display("FAIL speed_change got valid=%0d starts=%0d exp valid=198 starts at 0,66", run, starts.size());
    end
  endtask

  task automatic test_reset_mid();
    int start_acc, n_v;
    gen_speed = 2'd2;
    lane_0_tx_enc_old = rand132();
    lane_1_tx_enc_old = rand132();
    enable_ser = 1;
    tick();
    enable_ser = 0;
    start_acc = acc_total;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) begin
        lane_0_tx_enc_old = rand132();
        lane_1_tx_enc_old = rand132();
        enable_ser = 1;
      end
      tick();
      if (acc_total != start_acc) enable_ser = 0;
    end
    rst = 1;
    tick();
    n_checks++;
    if (dut_vec() !== 6'b0 || underflow_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid got=%b cnt=%0d exp=000000 cnt=0", dut_vec(), underflow_cnt);
    end
    rst = 0;
    n_v = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_vec cyc=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
      n_v += int'(tx_valid);
    end
    n_checks++;
    if (n_v != 0) begin
      n_fail++;
      $display("FAIL reset_mid_discard got valid=%0d exp valid=0", n_v);
    end
  endtask

  task automatic test_underflow_cnt();
    int n_uf;
    logic [15:0] want;
`ifdef SER_UNDERFLOW_CNT_EN
    want = 16'd5;
`else
    want = 16'd0;
`endif
    enable = 0; tick();
    enable = 1; tick();
    n_uf = 0;
    gen_speed = 2'd0;
    for (int s = 0; s < 5; s++) begin
      lane_0_tx_enc_old = rand132();
      lane_1_tx_enc_old = rand132();
      enable_ser = 1;
      tick();
      enable_ser = 0;
      for (int k = 0; k < 11; k++) begin
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL uf_vec sym=%0d cyc=%0d got=%b exp=%b", s, k, dut_vec(), exp_vec());
        end
        n_uf += int'(underflow);
        tick();
      end
    end
    n_checks++;
    if (n_uf != 5 || underflow_cnt !== want) begin
      n_fail++;
      $display("FAIL underflow_cnt got pulses=%0d cnt=%0d exp pulses=5 cnt=%0d", n_uf, underflow_cnt, want);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      enable_ser = ($urandom_range(0, 3) != 0);
      gen_speed  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      lane_0_tx_enc_old = rand132();
      lane_1_tx_enc_old = rand132();
      enable = ($urandom_range(0, 249) != 0);
      rst    = ($urandom_range(0, 599) == 0);
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec() || underflow_cnt !== exp_cnt()) begin
        n_fail++;
        $display("FAIL random_vec cyc=%0d got=%b cnt=%0d exp=%b cnt=%0d", k, dut_vec(), underflow_cnt, exp_vec(), exp_cnt());
      end
    end
    rst = 0; enable = 1; enable_ser = 0;
  endtask

  initial begin
    test_reset();
    test_gen2_single();
    test_gen3_back_to_back();
    test_gen4();
    test_speed_change();
    test_reset_mid();
    test_underflow_cnt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
